ps2_key_event_rx: RTL and testbench

//  PS/2 keyboard receiver: deserialises 11-bit frames, validates start/stop/odd parity, decodes the E0 (extended)
//  and F0 (break) prefixes into make/break key events, and buffers those events in a FIFO behind a valid/ready port.

---
 rtl/ps2_key_event_rx_pkg.sv | 32 +++
 rtl/ps2_key_event_rx_if.sv | 27 ++
 rtl/ps2_key_event_rx_fifo.sv | 48 ++++
 rtl/ps2_key_event_rx.sv | 188 ++++++++++++++++++
 tb/tb_ps2_key_event_rx.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_event_rx_pkg.sv
// PS/2 receiver shared definitions: scan codes,
// decoder state encoding and the event record.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] ARROW_L = 8'h6B;
    localparam logic [7:0] ARROW_R = 8'h74;
    localparam logic [7:0] ARROW_U = 8'h75;
    localparam logic [7:0] ARROW_D = 8'h72;

    localparam int EVT_W = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } dec_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    // start low, stop high, odd parity over data+parity
    function automatic logic frame_ok(input logic [10:0] f);
        return !f[0] && f[10] && (^f[9:1]);
    endfunction

endpackage

// File: rtl/ps2_key_event_rx_if.sv
// Key event valid/ready port between the PS/2
// receiver and its consumer.
interface ps2_key_event_rx_if;

    logic       EVT_VALID;
    logic       EVT_READY;
    logic [7:0] EVT_CODE;
    logic       EVT_EXT;
    logic       EVT_BREAK;

    modport master (
        output EVT_VALID,
        output EVT_CODE,
        output EVT_EXT,
        output EVT_BREAK,
        input  EVT_READY
    );

    modport slave (
        input  EVT_VALID,
        input  EVT_CODE,
        input  EVT_EXT,
        input  EVT_BREAK,
        output EVT_READY
    );

endinterface

// File: rtl/ps2_key_event_rx_fifo.sv
// Synchronous event FIFO with extended pointers;
// a pop in the same cycle frees a slot for a write.
module evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count   = wptr - rptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: frame deserialiser, E0/F0
// prefix decoder and buffered make/break event port.
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV       = 250,
    parameter int TIMEOUT_TICKS = 4000,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        PS2_CLK,
    input  logic                        PS2_DATA,
    ps2_key_event_rx_if.master          evt,
    output logic [$clog2(FIFO_DEPTH):0] EVT_COUNT,
    output logic                        FRAME_ERR,
    output logic                        OVERFLOW,
    input  logic                        CLR_ERR
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          prev_q;
    logic [DW-1:0] div_q;
    logic          tick, fall;
    logic [9:0]    sh_q;
    logic [10:0]   shifted;
    logic [3:0]    bcnt_q;
    logic [TW-1:0] to_q;
    logic          frm_vld_q, frm_bad_q, to_err_q;
    logic [7:0]    byte_q;

    dec_state_t    state_q, state_d;
    logic          push, dec_err, is_ext, is_brk;
    evt_t          wrec, head;
    logic [EVT_W-1:0] rdata;
    logic          full, empty, pop;

    assign tick    = (div_q == DW'(CLK_DIV - 1));
    assign fall    = prev_q && !clk_s2;
    assign shifted = {dat_s2, sh_q};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
            div_q  <= '0;
        end else begin
            clk_s1 <= PS2_CLK;
            clk_s2 <= clk_s1;
            dat_s1 <= PS2_DATA;
            dat_s2 <= dat_s1;
            div_q  <= tick ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prev_q    <= 1'b1;
            sh_q      <= '0;
            bcnt_q    <= '0;
            to_q      <= '0;
            frm_vld_q <= 1'b0;
            frm_bad_q <= 1'b0;
            to_err_q  <= 1'b0;
            byte_q    <= '0;
        end else begin
            frm_vld_q <= 1'b0;
            frm_bad_q <= 1'b0;
            to_err_q  <= 1'b0;
            if (tick) begin
                prev_q <= clk_s2;
                if (fall) begin
                    sh_q <= shifted[10:1];
                    to_q <= '0;
                    if (bcnt_q == 4'd10) begin
                        bcnt_q    <= '0;
                        byte_q    <= shifted[8:1];
                        frm_vld_q <= frame_ok(shifted);
                        frm_bad_q <= !frame_ok(shifted);
                    end else begin
                        bcnt_q <= bcnt_q + 1'b1;
                    end
                end else if (bcnt_q != '0) begin
                    if (to_q == TW'(TIMEOUT_TICKS - 1)) begin
                        bcnt_q   <= '0;
                        to_q     <= '0;
                        to_err_q <= 1'b1;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    assign is_ext = (byte_q == PS2_EXT);
    assign is_brk = (byte_q == PS2_BRK);

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        dec_err = 1'b0;
        wrec    = '{ext: 1'b0, brk: 1'b0, code: byte_q};
        if (frm_bad_q) begin
            state_d = S_IDLE;
        end else if (frm_vld_q) begin
            case (state_q)
                S_IDLE: begin
                    unique case (1'b1)
                        is_ext:  state_d = S_EXT;
                        is_brk:  state_d = S_BRK;
                        default: push = 1'b1;
                    endcase
                end
                S_EXT: begin
                    unique case (1'b1)
                        is_brk:  state_d = S_EXT_BRK;
                        is_ext:  state_d = S_EXT;
                        default: begin
                            push     = 1'b1;
                            wrec.ext = 1'b1;
                            state_d  = S_IDLE;
                        end
                    endcase
                end
                S_BRK, S_EXT_BRK: begin
                    state_d = S_IDLE;
                    if (is_ext || is_brk) begin
                        dec_err = 1'b1;
                    end else begin
                        push     = 1'b1;
                        wrec.brk = 1'b1;
                        wrec.ext = (state_q == S_EXT_BRK);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign pop = evt.EVT_VALID && evt.EVT_READY;

    evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (push),
        .wdata (wrec),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (EVT_COUNT)
    );

    // empty FIFO shows an all-zero head
    assign head          = empty ? '0 : evt_t'(rdata);
    assign evt.EVT_VALID = !empty;
    assign evt.EVT_CODE  = head.code;
    assign evt.EVT_EXT   = head.ext;
    assign evt.EVT_BREAK = head.brk;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            FRAME_ERR <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else if (CLR_ERR) begin
            FRAME_ERR <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else begin
            if (frm_bad_q || to_err_q || dec_err) FRAME_ERR <= 1'b1;
            if (push && full && !pop)             OVERFLOW  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Directed bench for ps2_key_event_rx: vector table
// plus latency, timeout, overflow and reset sequences.
module tb_ps2_key_event_rx;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic       CLR_ERR = 1'b0;
    logic [3:0] EVT_COUNT;
    logic       FRAME_ERR;
    logic       OVERFLOW;

    int checks = 0;
    int fails  = 0;

    ps2_key_event_rx_if evt_if ();

    ps2_key_event_rx #(
        .CLK_DIV       (4),
        .TIMEOUT_TICKS (64),
        .FIFO_DEPTH    (8)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .PS2_CLK   (PS2_CLK),
        .PS2_DATA  (PS2_DATA),
        .evt       (evt_if),
        .EVT_COUNT (EVT_COUNT),
        .FRAME_ERR (FRAME_ERR),
        .OVERFLOW  (OVERFLOW),
        .CLR_ERR   (CLR_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         nb;
        bit         bad;
        bit         ev;
        logic [7:0] code;
        bit         ext, brk, ferr;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad,
                              input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            PS2_DATA = f[i];
            wait_clk(10);
            PS2_CLK = 1'b0;
            wait_clk(20);
            PS2_CLK = 1'b1;
            wait_clk(10);
        end
    endtask

    task automatic clr_err();
        CLR_ERR = 1'b1;
        wait_clk(1);
        CLR_ERR = 1'b0;
        wait_clk(1);
    endtask

    task automatic pop_one();
        evt_if.EVT_READY = 1'b1;
        wait_clk(1);
        evt_if.EVT_READY = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] ovf_codes [9];
    logic [7:0] b;
    int         n;

    initial begin
        vecs[0] = '{8'h74, 8'h00, 8'h00, 1, 0, 1, 8'h74, 0, 0, 0};
        vecs[1] = '{8'hE0, 8'hF0, 8'h6B, 3, 0, 1, 8'h6B, 1, 1, 0};
        vecs[2] = '{8'h75, 8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 0, 1};
        vecs[3] = '{8'h72, 8'h00, 8'h00, 1, 0, 1, 8'h72, 0, 0, 0};
        vecs[4] = '{8'hF0, 8'h75, 8'h00, 2, 0, 1, 8'h75, 0, 1, 0};
        vecs[5] = '{8'hE0, 8'h74, 8'h00, 2, 0, 1, 8'h74, 1, 0, 0};
        vecs[6] = '{8'hF0, 8'hF0, 8'h00, 2, 0, 0, 8'h00, 0, 0, 1};
        vecs[7] = '{8'hE0, 8'hE0, 8'h6B, 3, 0, 1, 8'h6B, 1, 0, 0};
        ovf_codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                      8'h36, 8'h3D, 8'h3E, 8'h46};

        evt_if.EVT_READY = 1'b0;
        wait_clk(3);
        chk("rst_valid", evt_if.EVT_VALID, 0);
        chk("rst_count", EVT_COUNT, 0);
        chk("rst_code", evt_if.EVT_CODE, 0);
        chk("rst_ferr", FRAME_ERR, 0);
        chk("rst_ovf", OVERFLOW, 0);
        RST_N = 1'b1;
        wait_clk(5);

        // first frame with READY high: measure latency from 11th edge
        evt_if.EVT_READY = 1'b1;
        send_frame(8'h74, 0, 10);
        PS2_DATA = 1'b1;
        wait_clk(10);
        PS2_CLK = 1'b0;
        n = 0;
        while (!evt_if.EVT_VALID && n < 40) begin
            wait_clk(1);
            n++;
        end
        chk("lat_lo", (n >= 4), 1);
        chk("lat_hi", (n <= 7), 1);
        chk("lat_code", evt_if.EVT_CODE, 8'h74);
        chk("lat_ext", evt_if.EVT_EXT, 0);
        chk("lat_brk", evt_if.EVT_BREAK, 0);
        wait_clk(1);
        chk("lat_popped", evt_if.EVT_VALID, 0);
        wait_clk(19);
        PS2_CLK = 1'b1;
        wait_clk(10);
        evt_if.EVT_READY = 1'b0;

        for (int v = 0; v < 8; v++) begin
            for (int j = 0; j < vecs[v].nb; j++) begin
                b = (j == 0) ? vecs[v].b0 :
                    (j == 1) ? vecs[v].b1 : vecs[v].b2;
                send_frame(b, vecs[v].bad && (j == vecs[v].nb - 1), 11);
            end
            wait_clk(20);
            chk($sformatf("v%0d_count", v), EVT_COUNT, 32'(vecs[v].ev));
            chk($sformatf("v%0d_valid", v), evt_if.EVT_VALID, vecs[v].ev);
            chk($sformatf("v%0d_ferr", v), FRAME_ERR, vecs[v].ferr);
            if (vecs[v].ev) begin
                chk($sformatf("v%0d_code", v), evt_if.EVT_CODE, vecs[v].code);
                chk($sformatf("v%0d_ext", v), evt_if.EVT_EXT, vecs[v].ext);
                chk($sformatf("v%0d_brk", v), evt_if.EVT_BREAK, vecs[v].brk);
                pop_one();
                chk($sformatf("v%0d_drained", v), EVT_COUNT, 0);
            end
            clr_err();
            chk($sformatf("v%0d_clr", v), FRAME_ERR, 0);
        end

        // partial frame then silence longer than the timeout
        send_frame(8'h55, 0, 6);
        wait_clk(300);
        chk("to_ferr", FRAME_ERR, 1);
        chk("to_count", EVT_COUNT, 0);
        clr_err();
        send_frame(8'h72, 0, 11);
        wait_clk(20);
        chk("to_next_valid", evt_if.EVT_VALID, 1);
        chk("to_next_code", evt_if.EVT_CODE, 8'h72);
        chk("to_next_ferr", FRAME_ERR, 0);
        pop_one();

        // fill past capacity with consumer stalled
        for (int i = 0; i < 9; i++) send_frame(ovf_codes[i], 0, 11);
        wait_clk(20);
        chk("ovf_count", EVT_COUNT, 8);
        chk("ovf_flag", OVERFLOW, 1);
        chk("ovf_ferr", FRAME_ERR, 0);
        evt_if.EVT_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), evt_if.EVT_CODE, ovf_codes[i]);
            wait_clk(1);
        end
        evt_if.EVT_READY = 1'b0;
        chk("drain_empty", evt_if.EVT_VALID, 0);

        // reset in the middle of a break sequence
        send_frame(8'hF0, 0, 11);
        send_frame(8'h6B, 0, 4);
        RST_N = 1'b0;
        wait_clk(2);
        chk("mid_rst_valid", evt_if.EVT_VALID, 0);
        chk("mid_rst_count", EVT_COUNT, 0);
        chk("mid_rst_ovf", OVERFLOW, 0);
        chk("mid_rst_ferr", FRAME_ERR, 0);
        RST_N = 1'b1;
        wait_clk(5);
        send_frame(8'h6B, 0, 11);
        wait_clk(20);
        chk("post_rst_count", EVT_COUNT, 1);
        chk("post_rst_code", evt_if.EVT_CODE, 8'h6B);
        chk("post_rst_brk", evt_if.EVT_BREAK, 0);
        chk("post_rst_ext", evt_if.EVT_EXT, 0);
        chk("post_rst_ferr", FRAME_ERR, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
